// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the off-chip memory arbiter and the caches
// that sit in front of it.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 256;

    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY0,
        BUSY1
    } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the single off-chip memory port; one
// transaction in flight, locked to its owner until the memory acknowledges.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic              p0_ack_o,

    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic              p1_ack_o,

    output logic [DATA_W-1:0] rd_data_o,

    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,

    output logic [1:0]        grant_o
);

    state_t state;
    logic   last_grant;
    logic   pick_p1;

    // Port 1 wins when it is alone, or on a tie when port 0 was served last.
    assign pick_p1 = p1_enable_i & (~p0_enable_i | (last_grant == 1'(PORT_I)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            last_grant   <= 1'(PORT_D);
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            grant_o      <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (p0_enable_i | p1_enable_i) begin
                        mem_enable_o <= 1'b1;
                        if (pick_p1) begin
                            mem_write_o <= p1_write_i;
                            mem_addr_o  <= p1_addr_i;
                            mem_data_o  <= p1_data_i;
                            last_grant  <= 1'(PORT_D);
                            grant_o     <= 2'b10;
                            state       <= BUSY1;
                        end else begin
                            mem_write_o <= p0_write_i;
                            mem_addr_o  <= p0_addr_i;
                            mem_data_o  <= p0_data_i;
                            last_grant  <= 1'(PORT_I);
                            grant_o     <= 2'b01;
                            state       <= BUSY0;
                        end
                    end
                end
                BUSY0, BUSY1: begin
                    if (mem_ack_i) begin
                        mem_enable_o <= 1'b0;
                        grant_o      <= 2'b00;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A memory ack seen in IDLE matches no owner and is dropped here.
    assign p0_ack_o  = mem_ack_i & (state == BUSY0);
    assign p1_ack_o  = mem_ack_i & (state == BUSY1);
    assign rd_data_o = mem_data_i;

    // The owner must keep its request up until it has seen its ack.
    owner0_holds: assert property (@(posedge clk_i) disable iff (rst_i)
        (state == BUSY0) |-> p0_enable_i);
    owner1_holds: assert property (@(posedge clk_i) disable iff (rst_i)
        (state == BUSY1) |-> p1_enable_i);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: requester/memory drivers push expectations,
// a negedge monitor pops and compares memory grants and port acks.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 256;
    localparam int TXN_W = 2 + 1 + AW + DW;
    localparam int ACK_W = 2 + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_enable, p0_write, p0_ack;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_data;
    logic          p1_enable, p1_write, p1_ack;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_data;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          mem_enable, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [1:0]    grant;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mem_lat = 3;
    int spur_req = 0;
    bit chk_gap = 1'b0;
    int gap_base = 0;
    int n_starts = 0;
    int last_ack_cyc = 0;

    logic [TXN_W-1:0] exp_q[$];
    logic [ACK_W-1:0] ack_q[$];

    mem_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .p0_enable_i (p0_enable),
        .p0_write_i  (p0_write),
        .p0_addr_i   (p0_addr),
        .p0_data_i   (p0_data),
        .p0_ack_o    (p0_ack),
        .p1_enable_i (p1_enable),
        .p1_write_i  (p1_write),
        .p1_addr_i   (p1_addr),
        .p1_data_i   (p1_data),
        .p1_ack_o    (p1_ack),
        .rd_data_o   (rd_data),
        .mem_data_i  (mem_rdata),
        .mem_ack_i   (mem_ack),
        .mem_enable_o(mem_enable),
        .mem_write_o (mem_write),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_data),
        .grant_o     (grant)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [TXN_W-1:0] act,
                         input logic [TXN_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model ----------------
    // Acks mem_lat cycles after enable first rises; spur_req bumps inject an
    // unsolicited one-cycle ack.
    initial begin
        int cnt;
        int spur_done;
        cnt = 0;
        spur_done = 0;
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (spur_req != spur_done) begin
                spur_done = spur_req;
                mem_ack = 1'b1;
            end else if (mem_enable) begin
                cnt++;
                if (cnt > mem_lat) mem_ack = 1'b1;
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [TXN_W-1:0] cur;
        logic [TXN_W-1:0] e;
        logic [ACK_W-1:0] ea;
        bit prev_en;
        prev_en = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (cyc > 20000) begin
                $display("FAIL watchdog: got cycle %0d want < 20000", cyc);
                $fatal(1, "watchdog expired");
            end
            if (rst) begin
                prev_en = 1'b0;
                continue;
            end
            if (p0_ack && p1_ack) check("dual_ack", {p1_ack, p0_ack}, 2'b00);
            if (p0_ack || p1_ack) begin
                last_ack_cyc = cyc;
                if (ack_q.size() == 0) begin
                    check("ack_unexpected", {p1_ack, p0_ack}, 2'b00);
                end else begin
                    ea = ack_q.pop_front();
                    check("ack", {p1_ack, p0_ack, rd_data}, ea);
                end
            end
            if (mem_enable && !prev_en) begin
                n_starts++;
                cur = {grant, mem_write, mem_addr, mem_data};
                if (exp_q.size() == 0) begin
                    check("start_unexpected", mem_enable, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("start", cur, e);
                end
                if (chk_gap && n_starts > gap_base + 1)
                    check("idle_gap", cyc - last_ack_cyc, 2);
            end else if (mem_enable) begin
                check("hold", {grant, mem_write, mem_addr, mem_data}, cur);
            end else begin
                check("idle_grant", grant, 2'b00);
            end
            prev_en = mem_enable;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_txn(input logic [1:0] g, input logic wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({g, wr, a, d});
    endtask

    task automatic push_ack(input logic [1:0] who, input logic [DW-1:0] d);
        ack_q.push_back({who, d});
    endtask

    task automatic drive(input int port, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        if (port == 0) begin
            p0_enable = 1'b1; p0_write = wr; p0_addr = a; p0_data = d;
        end else begin
            p1_enable = 1'b1; p1_write = wr; p1_addr = a; p1_data = d;
        end
    endtask

    // Waits for this port's ack (or reset), then drops enable on the next edge.
    task automatic wait_ack(input int port, input bit want);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rst) break;
            if ((port == 0) ? p0_ack : p1_ack) begin
                got = 1'b1;
                check("en_at_ack", mem_enable, 1'b1);
                break;
            end
        end
        check(port == 0 ? "ack_seen_p0" : "ack_seen_p1", got, want);
        @(posedge clk);
        #1;
        if (port == 0) p0_enable = 1'b0;
        else p1_enable = 1'b0;
    endtask

    task automatic req(input int port, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit want);
        drive(port, wr, a, d);
        wait_ack(port, want);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        p0_enable = 0; p0_write = 0; p0_addr = '0; p0_data = '0;
        p1_enable = 0; p1_write = 0; p1_addr = '0; p1_data = '0;
        mem_rdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {grant, mem_enable, mem_write, mem_addr, mem_data}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single read on port 1 with slow memory; check one-cycle grant latency.
        mem_lat = 10;
        mem_rdata = {32{8'hA5}};
        push_txn(2'b10, 1'b0, 32'h0000_0400, '0);
        push_ack(2'b10, {32{8'hA5}});
        drive(1, 1'b0, 32'h0000_0400, '0);
        @(negedge clk);
        check("lat_cycle_n", mem_enable, 1'b0);
        @(negedge clk);
        check("lat_cycle_n1", mem_enable, 1'b1);
        wait_ack(1, 1'b1);
        repeat (2) @(posedge clk);

        // Simultaneous first tie: port 0 first, port 1 after one idle cycle.
        mem_lat = 3;
        mem_rdata = {8{32'hDEAD_BEEF}};
        chk_gap = 1'b1;
        gap_base = n_starts;
        push_txn(2'b01, 1'b0, 32'h100, '0);
        push_ack(2'b01, {8{32'hDEAD_BEEF}});
        push_txn(2'b10, 1'b1, 32'h200, 256'h1234);
        push_ack(2'b10, {8{32'hDEAD_BEEF}});
        fork
            req(0, 1'b0, 32'h100, '0, 1'b1);
            req(1, 1'b1, 32'h200, 256'h1234, 1'b1);
        join
        repeat (2) @(posedge clk);

        // Both ports keep requesting: grants alternate 0,1,0,1.
        gap_base = n_starts;
        mem_rdata = {16{16'h5A3C}};
        push_txn(2'b01, 1'b0, 32'h1000, '0);        push_ack(2'b01, {16{16'h5A3C}});
        push_txn(2'b10, 1'b1, 32'h2000, 256'hAA);   push_ack(2'b10, {16{16'h5A3C}});
        push_txn(2'b01, 1'b1, 32'h1040, 256'hBB);   push_ack(2'b01, {16{16'h5A3C}});
        push_txn(2'b10, 1'b0, 32'h2040, 256'hCC);   push_ack(2'b10, {16{16'h5A3C}});
        fork
            begin
                req(0, 1'b0, 32'h1000, '0, 1'b1);
                req(0, 1'b1, 32'h1040, 256'hBB, 1'b1);
            end
            begin
                req(1, 1'b1, 32'h2000, 256'hAA, 1'b1);
                req(1, 1'b0, 32'h2040, 256'hCC, 1'b1);
            end
        join
        repeat (2) @(posedge clk);

        // Port 0 waits behind a busy port 1 and changes its address meanwhile.
        gap_base = n_starts;
        mem_lat = 10;
        mem_rdata = {4{64'h0123_4567_89AB_CDEF}};
        push_txn(2'b10, 1'b0, 32'h500, 256'h77);
        push_ack(2'b10, {4{64'h0123_4567_89AB_CDEF}});
        push_txn(2'b01, 1'b0, 32'h340, 256'h99);
        push_ack(2'b01, {4{64'h0123_4567_89AB_CDEF}});
        fork
            req(1, 1'b0, 32'h500, 256'h77, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #1;
                p0_enable = 1'b1; p0_write = 1'b0; p0_addr = 32'h300; p0_data = 256'h99;
                repeat (3) @(posedge clk);
                #1;
                p0_addr = 32'h340;
                wait_ack(0, 1'b1);
            end
        join
        chk_gap = 1'b0;
        repeat (2) @(posedge clk);

        // Unsolicited memory ack while idle.
        spur_req++;
        @(posedge clk);
        @(negedge clk);
        check("spur_acks", {p1_ack, p0_ack, mem_enable}, 3'b000);
        @(negedge clk);
        check("spur_after", {grant, mem_enable}, 3'b000);

        // Reset three cycles into a port 0 transaction.
        mem_rdata = {32{8'h3C}};
        push_txn(2'b01, 1'b0, 32'h600, '0);
        fork
            req(0, 1'b0, 32'h600, '0, 1'b0);
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (mem_enable) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("rst_busy_started", seen, 1'b1);
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check("rst_busy_out", {grant, mem_enable, p0_ack, p1_ack}, 5'b0);
            end
        join
        repeat (2) @(posedge clk);

        mem_lat = 3;
        push_txn(2'b10, 1'b1, 32'h0000_0700, 256'hF00D);
        push_ack(2'b10, {32{8'h3C}});
        req(1, 1'b1, 32'h0000_0700, 256'hF00D, 1'b1);
        repeat (4) @(posedge clk);

        @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("ack_q_empty", ack_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single off-chip data memory port between two cache controllers: port 0 (instruction-cache refill) and port 1 (dcache_controller).
- Sits between the caches and the memory model: caches drive request bundles, and the arbiter drives mem_enable_o/mem_write_o/mem_addr_o/mem_data_o.
- One transaction is outstanding at a time; it is locked to its owner until mem_ack_i.
- Ties are resolved round-robin, so neither cache starves.

Parameters:
- ADDR_W, 32, byte address width of requests and memory port
- DATA_W, 256, cache-line width carried on the memory data buses

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- p0_enable_i  in  1  port 0 request, level-held until p0_ack_o
- p0_write_i  in  1  port 0 write (1) / read (0)
- p0_addr_i  in  ADDR_W  port 0 line address
- p0_data_i  in  DATA_W  port 0 write data
- p0_ack_o  out  1  port 0 transaction complete
- p1_enable_i  in  1  port 1 request, level-held until p1_ack_o
- p1_write_i  in  1  port 1 write / read
- p1_addr_i  in  ADDR_W  port 1 line address
- p1_data_i  in  DATA_W  port 1 write data
- p1_ack_o  out  1  port 1 transaction complete
- rd_data_o  out  DATA_W  read data to both ports (qualified by the acks)
- mem_data_i  in  DATA_W  memory read data
- mem_ack_i  in  1  memory completion pulse
- mem_enable_o  out  1  memory request, held until mem_ack_i
- mem_write_o  out  1  memory write
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  DATA_W  memory write data
- grant_o  out  2  one-hot current owner; 00 when idle (debug/perf)

Behaviour:
- Clock is clk_i; reset rst_i is synchronous and active-high.
- Reset values:
  - state=IDLE, last_grant=1 (so port 0 wins the first tie)
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, grant_o=00
- States: IDLE, BUSY0, BUSY1.
- IDLE:
  - No enable asserted: stay in IDLE; memory outputs hold enable=0.
  - Exactly one enable asserted: grant that port.
  - Both asserted: grant the port != last_grant.
  - On the grant edge, register the winner's write/addr/data into mem_*, set mem_enable_o=1 and update last_grant. Next state is BUSY0 or BUSY1.
- Latency: a request first seen high in cycle N gives mem_enable_o=1 in cycle N+1.
- BUSYx:
  - mem_* stay constant; other port's inputs are ignored.
  - When mem_ack_i=1, px_ack_o=1 in that same cycle (combinational: mem_ack_i & owner). rd_data_o is mem_data_i passed through unconditionally.
  - On that edge, mem_enable_o←0, grant_o←00, state→IDLE.
- At least one IDLE cycle always separates two memory transactions; a back-to-back request is granted in that IDLE cycle.
- Requester contract: drop enable on the edge after its ack. The arbiter samples enables only in IDLE, so a dropped request is never re-issued.
- mem_ack_i in IDLE is spurious: ignored, no ack_o, no state change.
- Owner deasserting enable mid-BUSY is illegal. The arbiter still completes the transaction and pulses ack; an assertion flags it in simulation.
- Both acks are never high together.
- rst_i mid-BUSY: all state and outputs return to reset values next edge, and any pending ack is dropped. Requesters are reset by the same rst_i.
- mem_write_o reads (0) still present mem_data_o = the captured data; the memory ignores it.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, BUSY0, BUSY1}
  - localparams PORT_I=0, PORT_D=1
  - default ADDR_W/DATA_W constants shared with dcache_controller
- No sub-module: the round-robin pick is a 2-input expression inside mem_arbiter.

Test Plan:
- Single read, port 1 addr 0x0000_0400, memory acks 10 cycles after enable with data 0xA5..A5 -> mem_enable_o high cycle N+1 through the ack cycle, mem_addr_o=0x400, mem_write_o=0, p1_ack_o one pulse with rd_data_o=0xA5..A5, p0_ack_o never high.
- Simultaneous first requests (p0 read 0x100, p1 write 0x200 data 0x1234) -> p0 served first (last_grant reset=1). One IDLE cycle follows, then p1 with mem_addr_o=0x200, mem_write_o=1, mem_data_o=0x1234.
- Both ports hold requests continuously for 4 transactions -> grants alternate 0,1,0,1. Each ack goes only to the owner, and grant_o matches.
- p0 requests while p1 is BUSY; p0 changes addr 0x300→0x340 before its grant -> mem_addr_o for p0 = 0x340 (value sampled at grant). p1 outputs stay unchanged during BUSY.
- mem_ack_i pulsed while IDLE -> no ack_o, grant_o=00, mem_enable_o stays 0.
- rst_i asserted 3 cycles into a BUSY0 transaction -> next cycle mem_enable_o=0, grant_o=00, and a later p1-only request is granted normally.
